// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous INST_SRAM and
// hands {pc, inst} to decode with a one-entry buffer for decode stalls.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] INST_NOP = if_pkg::INST_NOP
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_allowin,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] buf_inst_r, buf_inst_s;
  logic [31:0] pc_next_s;
  logic [31:0] br_addr_s;

  assign inst_sram_wen   = 1'b0;
  assign inst_sram_wdata = 32'h0000_0000;
  assign pc_next_s       = pc_r + PC_STEP;
  assign br_addr_s       = align_word(br_target);

  // Request, presentation and next-state decode; a redirect overrides everything.
  always_comb begin
    inst_sram_en   = 1'b0;
    inst_sram_addr = pc_r;
    if_valid       = 1'b0;
    if_pc          = pc_r;
    if_inst        = INST_NOP;
    state_s        = state_r;
    pc_s           = pc_r;
    buf_inst_s     = buf_inst_r;
    if (!reset) begin
      inst_sram_addr = RESET_PC;
      if_pc          = RESET_PC;
    end else begin
      case (state_r)
        S_IDLE: begin
          inst_sram_en   = 1'b1;
          inst_sram_addr = RESET_PC;
          pc_s           = RESET_PC;
          state_s        = S_FETCH;
        end
        S_FETCH, S_HOLD: begin
          if (br_taken) begin
            inst_sram_en   = 1'b1;
            inst_sram_addr = br_addr_s;
            pc_s           = br_addr_s;
            state_s        = S_FETCH;
          end else begin
            if_valid = 1'b1;
            if_inst  = (state_r == S_FETCH) ? inst_sram_rdata : buf_inst_r;
            if (id_allowin) begin
              inst_sram_en   = 1'b1;
              inst_sram_addr = pc_next_s;
              pc_s           = pc_next_s;
              state_s        = S_FETCH;
            end else begin
              // SRAM output is not guaranteed stable once en drops, so capture it now.
              if (state_r == S_FETCH) begin
                buf_inst_s = inst_sram_rdata;
              end else begin
                buf_inst_s = buf_inst_r;
              end
              state_s = S_HOLD;
            end
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // State, PC and hold-buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      pc_r       <= RESET_PC;
      buf_inst_r <= INST_NOP;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      buf_inst_r <= buf_inst_s;
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of INST_SRAM.
- Owns the PC and drives the SRAM request port (en/wen/addr/wdata), treating the SRAM as synchronous: read data is valid the cycle after the request edge.
- Presents {pc, inst} to decode with a valid/allowin handshake, and buffers one instruction when decode stalls.
- Accepts branch redirects from a later stage and squashes in-flight or buffered fetches.

Parameters:
- RESET_PC, 32'h8000_0000, address of the first fetch after reset release.
- INST_NOP, 32'h0000_0013, value driven on if_inst whenever if_valid=0.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_sram_en  out  1  read request; sampled by SRAM at rising edge.
- inst_sram_wen  out  1  tied 0 (fetch never writes).
- inst_sram_addr  out  32  request address; always word-aligned.
- inst_sram_wdata  out  32  tied 0.
- inst_sram_rdata  in  32  read data, valid the cycle after an accepted request.
- br_taken  in  1  redirect request from execute; combinational input.
- br_target  in  32  redirect address; bits [1:0] ignored (forced 0).
- id_allowin  in  1  decode can accept an instruction this cycle.
- if_valid  out  1  {if_pc, if_inst} valid to decode.
- if_pc  out  32  PC of the presented instruction.
- if_inst  out  32  presented instruction.

Behaviour:
- Registers: state, pc_q (PC of the instruction in the response slot or buffer), buf_inst.
- States:
  - S_IDLE: reset state.
  - S_FETCH: SRAM response for pc_q is on inst_sram_rdata this cycle.
  - S_HOLD: instruction for pc_q is held in buf_inst.
- While reset==0:
  - state=S_IDLE, pc_q=RESET_PC, buf_inst=INST_NOP.
  - Outputs: en=0, if_valid=0, addr=RESET_PC, if_pc=RESET_PC, if_inst=INST_NOP.
- en/addr/if_* are combinational from state, pc_q, br_taken and id_allowin. The request takes effect at the next rising edge.
- S_IDLE (reset released):
  - en=1, addr=RESET_PC, if_valid=0.
  - Next: pc_q<=RESET_PC, →S_FETCH.
  - br_taken is ignored in S_IDLE.
- S_FETCH:
  - if_valid=1, if_pc=pc_q, if_inst=inst_sram_rdata.
  - If id_allowin: en=1, addr=pc_q+4; pc_q<=pc_q+4; stay in S_FETCH (one instruction per cycle).
  - If ~id_allowin: en=0; buf_inst<=inst_sram_rdata; →S_HOLD.
- S_HOLD:
  - if_valid=1, if_pc=pc_q, if_inst=buf_inst, en=0.
  - If id_allowin: en=1, addr=pc_q+4; pc_q<=pc_q+4; →S_FETCH.
- Redirect (br_taken=1 in S_FETCH or S_HOLD) takes highest priority:
  - if_valid forced 0 the same cycle; decode must not consume.
  - en=1, addr={br_target[31:2],2'b00}; pc_q<=that address; →S_FETCH.
  - Any response or buffered instruction is discarded.
  - First redirected instruction is valid exactly one cycle after br_taken.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
- Simultaneous br_taken & id_allowin: redirect wins; no handshake completes that cycle.
- Reset asserted mid-operation: immediate return to reset values. The pending SRAM response is ignored; restart fetches RESET_PC.
- Latency: reset release → first if_valid in 2 cycles (IDLE, FETCH). Steady-state throughput is 1 inst/cycle.
- Decode stall costs no bubble: the HOLD→FETCH re-request makes the next instruction valid the cycle after release.
- inst_sram_rdata is never assumed stable across cycles with en=0; the buffer covers this.

Decomposition:
- Shared package if_pkg holds:
  - state enum {S_IDLE, S_FETCH, S_HOLD};
  - RESET_PC_DEFAULT;
  - INST_NOP;
  - PC_STEP=32'd4.
- No sub-module; the one-entry hold buffer is inline.

Test Plan:
- Reset release, id_allowin=1, SRAM model preloaded:
  - cycle 0: en=1, addr=80000000.
  - cycle 1: if_valid=1, if_pc=80000000, addr=80000004.
  - then consecutive PCs every cycle.
- Stall: drop id_allowin for 3 cycles while if_pc=80000008, with rdata changed to garbage after the first stall cycle → if_inst holds the original word, en=0, if_pc=80000008 throughout. Re-raise → next cycle if_pc=8000000C.
- Redirect in S_FETCH with br_target=80000103 → same cycle if_valid=0, addr=80000100. Next cycle if_pc=80000100.
- Redirect during S_HOLD together with id_allowin=1 → buffered inst dropped (decode sees no handshake), then if_pc=br_target.
- Wrap: force pc_q=FFFFFFFC via redirect → following fetch addr=00000000.
- Async reset asserted mid-stream between edges → outputs return to reset values immediately. After release, fetch restarts at 80000000 and never presents a stale instruction.
